echo_fifo: RTL and testbench

- Parametrised, buffered successor to the wire-level UART echo block.
- Sits between the rxuart byte strobe interface and the txuart write interface.
- Queues received bytes in a FIFO and echoes them back in one of four modes: raw, upper-case, line-buffered, or sink.
- Counts receive errors and flags overflow so hardware UART loopback tests run at full rate without silent loss.

---
 rtl/echo_fifo.sv | 136 +++++++++++++
 tb/tb_echo_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : echo_fifo
// Purpose  : Buffered UART echo (raw / upper-case / line / sink) between the
//            rxuart strobe interface and the txuart write interface.
//            Optional macro ECHO_CRLF_EN: insert 0x0A after every echoed 0x0D.
// Revision : 1.0
// ============================================================================
module echo_fifo #(
  parameter int LGFIFO = 4,
  parameter int ERRW   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [1:0]        i_mode,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_err,
  input  logic              i_rx_break,
  input  logic              i_tx_busy,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_break,
  output logic [LGFIFO:0]   o_fill,
  output logic              o_overflow,
  output logic [ERRW-1:0]   o_err_count
);

  localparam int C_DEPTH = 1 << LGFIFO;
  localparam logic [1:0] C_MODE_UPPER = 2'b01;
  localparam logic [1:0] C_MODE_LINE  = 2'b10;
  localparam logic [1:0] C_MODE_SINK  = 2'b11;

  logic [7:0]        r_mem [C_DEPTH];
  logic [LGFIFO:0]   r_wptr, r_rptr, r_cptr;
  logic              r_tx_stb;
  logic [7:0]        r_tx_data;
  logic              r_tx_break;
  logic              r_overflow;
  logic [ERRW-1:0]   r_err_count;

  logic [LGFIFO:0]   w_fill, w_wptr_nxt;
  logic              w_full, w_accept, w_wr, w_ovf, w_err;
  logic              w_release, w_avail, w_xfer, w_slot, w_inject, w_pop;
  logic [7:0]        w_wr_data;

  assign w_fill = r_wptr - r_rptr;
  assign w_full = (r_wptr[LGFIFO] != r_rptr[LGFIFO]) &&
                  (r_wptr[LGFIFO-1:0] == r_rptr[LGFIFO-1:0]);

  // Break suppresses every write-side effect, including error counting.
  assign w_accept = i_rx_stb && !i_rx_break && !i_rx_err && (i_mode != C_MODE_SINK);
  assign w_wr     = w_accept && !w_full;
  assign w_ovf    = w_accept && w_full;
  assign w_err    = i_rx_stb && !i_rx_break && i_rx_err;

  assign w_wr_data = ((i_mode == C_MODE_UPPER) && (i_rx_data >= 8'h61) && (i_rx_data <= 8'h7A))
                     ? (i_rx_data - 8'h20) : i_rx_data;

  assign w_wptr_nxt = r_wptr + {{LGFIFO{1'b0}}, w_wr};

  // Line mode holds bytes until end-of-line, or until the FIFO fills so the
  // writer can never deadlock against an uncommitted full buffer.
  assign w_release = (i_mode != C_MODE_LINE) ||
                     (w_wr && ((i_rx_data == 8'h0D) || (i_rx_data == 8'h0A) ||
                               (w_fill == (LGFIFO+1)'(C_DEPTH-1))));

  assign w_avail = (r_rptr != r_cptr);
  assign w_xfer  = r_tx_stb && !i_tx_busy;
  assign w_slot  = !r_tx_stb || w_xfer;

`ifdef ECHO_CRLF_EN
  // The 0x0A is loaded in the same cycle the 0x0D leaves, ahead of the head.
  assign w_inject = w_xfer && (r_tx_data == 8'h0D);
`else
  assign w_inject = 1'b0;
`endif

  assign w_pop = w_slot && w_avail && !w_inject;

  always_ff @(posedge i_clk) begin
    if (w_wr)
      r_mem[r_wptr[LGFIFO-1:0]] <= w_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cptr      <= '0;
      r_tx_stb    <= 1'b0;
      r_tx_data   <= 8'h00;
      r_tx_break  <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_tx_break <= i_rx_break;
      if (w_ovf)
        r_overflow <= 1'b1;
      if (w_err && (r_err_count != {ERRW{1'b1}}))
        r_err_count <= r_err_count + 1'b1;

      if (i_rx_break) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_cptr   <= '0;
        r_tx_stb <= 1'b0;
      end else begin
        r_wptr <= w_wptr_nxt;
        if (w_pop)
          r_rptr <= r_rptr + 1'b1;
        if (w_release)
          r_cptr <= w_wptr_nxt;

        if (w_inject) begin
          r_tx_stb  <= 1'b1;
          r_tx_data <= 8'h0A;
        end else if (w_pop) begin
          r_tx_stb  <= 1'b1;
          r_tx_data <= r_mem[r_rptr[LGFIFO-1:0]];
        end else if (w_xfer) begin
          r_tx_stb  <= 1'b0;
        end
      end
    end
  end

  assign o_tx_stb    = r_tx_stb;
  assign o_tx_data   = r_tx_data;
  assign o_tx_break  = r_tx_break;
  assign o_fill      = w_fill;
  assign o_overflow  = r_overflow;
  assign o_err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_fifo
// Purpose  : Directed self-checking bench for echo_fifo (LGFIFO=2, ERRW=2).
// Revision : 1.0
// ============================================================================
module tb_echo_fifo;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       rx_stb;
  logic [7:0] rx_data;
  logic       rx_err;
  logic       rx_brk;
  logic       tx_busy;
  logic       tx_stb;
  logic [7:0] tx_data;
  logic       tx_brk;
  logic [2:0] fill;
  logic       ovf;
  logic [1:0] errc;

  int n_chk  = 0;
  int n_pass = 0;
  int stb_cnt = 0;
  logic [7:0] q[$];

  echo_fifo #(.LGFIFO(2), .ERRW(2)) u_dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_mode      (mode),
    .i_rx_stb    (rx_stb),
    .i_rx_data   (rx_data),
    .i_rx_err    (rx_err),
    .i_rx_break  (rx_brk),
    .i_tx_busy   (tx_busy),
    .o_tx_stb    (tx_stb),
    .o_tx_data   (tx_data),
    .o_tx_break  (tx_brk),
    .o_fill      (fill),
    .o_overflow  (ovf),
    .o_err_count (errc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitted-byte capture, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && tx_stb && !tx_busy)
      q.push_back(tx_data);
    if (tx_stb)
      stb_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic e);
    @(posedge clk); #1;
    rx_stb  = 1'b1;
    rx_data = d;
    rx_err  = e;
    @(posedge clk); #1;
    rx_stb  = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_bytes(input string tag, input logic [7:0] exp[$]);
    for (int i = 0; i < 200 && q.size() < exp.size(); i++) begin
      @(posedge clk); #1;
    end
    idle(2);
    check({tag, "_count"}, q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check({tag, "_byte"}, (q.size() > i) ? {24'h0, q[i]} : 32'hDEAD, {24'h0, exp[i]});
  endtask

  initial begin
    logic [7:0] exp[$];
    int base;
    rst_n = 1'b0; mode = 2'b00; rx_stb = 1'b0; rx_data = 8'h00;
    rx_err = 1'b0; rx_brk = 1'b0; tx_busy = 1'b0;
    idle(3);
    check("rst_stb",  tx_stb,  0);
    check("rst_data", tx_data, 0);
    check("rst_fill", fill,    0);
    check("rst_ovf",  ovf,     0);
    check("rst_err",  errc,    0);
    check("rst_brk",  tx_brk,  0);
    rst_n = 1'b1;
    idle(2);

    // Raw echo latency: strobe in cycle N, tx_stb in N+2 for one cycle
    send(8'h41, 1'b0);
    check("raw_n1_stb",  tx_stb, 0);
    check("raw_n1_fill", fill,   1);
    idle(1);
    check("raw_n2_stb",  tx_stb,  1);
    check("raw_n2_data", tx_data, 8'h41);
    check("raw_n2_fill", fill,    0);
    idle(1);
    check("raw_n3_stb",  tx_stb,  0);
    idle(2);
    q.delete();

    // Upper-case
    mode = 2'b01;
    send(8'h61, 1'b0); send(8'h7A, 1'b0); send(8'h7B, 1'b0); send(8'h31, 1'b0);
    exp = '{8'h41, 8'h5A, 8'h7B, 8'h31};
    expect_bytes("upper", exp);
    q.delete();

    // Line mode: held until CR
    mode = 2'b10;
    send(8'h68, 1'b0); send(8'h69, 1'b0);
    idle(3);
    check("line_hold_stb",  tx_stb, 0);
    check("line_hold_fill", fill,   2);
    send(8'h0D, 1'b0);
`ifdef ECHO_CRLF_EN
    exp = '{8'h68, 8'h69, 8'h0D, 8'h0A};
`else
    exp = '{8'h68, 8'h69, 8'h0D};
`endif
    expect_bytes("line_cr", exp);
    q.delete();

    // Line mode: forced release when the FIFO fills
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0);
    idle(3);
    check("line_force_hold", fill, 3);
    send(8'h64, 1'b0);
    exp = '{8'h61, 8'h62, 8'h63, 8'h64};
    expect_bytes("line_force", exp);
    q.delete();
    mode = 2'b00;

    // Overflow with stalled transmitter
    check("ovf_before", ovf, 0);
    tx_busy = 1'b1;
    for (int i = 1; i <= 6; i++)
      send(8'(i), 1'b0);
    idle(2);
    check("ovf_fill",    fill,    4);
    check("ovf_flag",    ovf,     1);
    check("ovf_stb",     tx_stb,  1);
    check("ovf_hold",    tx_data, 8'h01);
    tx_busy = 1'b0;
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_bytes("ovf_drain", exp);
    check("ovf_sticky", ovf, 1);
    q.delete();

    // Errors (saturating at 3 with ERRW=2) and sink mode
    send(8'h11, 1'b1); send(8'h12, 1'b1); send(8'h13, 1'b1);
    idle(1);
    check("err_count", errc, 3);
    send(8'h14, 1'b1);
    idle(1);
    check("err_sat",  errc, 3);
    check("err_fill", fill, 0);
    mode = 2'b11;
    base = stb_cnt;
    send(8'h21, 1'b0); send(8'h22, 1'b0);
    idle(4);
    check("sink_stb",  stb_cnt - base, 0);
    check("sink_fill", fill, 0);
    check("sink_err",  errc, 3);
    mode = 2'b00;

    // Break flushes queue and output register
    tx_busy = 1'b1;
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    idle(1);
    check("brk_pre_stb",  tx_stb, 1);
    check("brk_pre_fill", fill,   2);
    rx_brk = 1'b1;
    idle(1);
    check("brk_fwd",  tx_brk, 1);
    check("brk_fill", fill,   0);
    check("brk_stb",  tx_stb, 0);
    rx_stb = 1'b1; rx_data = 8'h77;
    idle(1);
    rx_stb = 1'b0;
    idle(3);
    check("brk_ignore", fill, 0);
    rx_brk = 1'b0;
    idle(1);
    check("brk_release", tx_brk, 0);
    check("brk_keep_ovf", ovf,  1);
    check("brk_keep_err", errc, 3);
    tx_busy = 1'b0;

    // Asynchronous reset mid-transfer
    tx_busy = 1'b1;
    send(8'h55, 1'b0);
    for (int i = 0; i < 10 && !tx_stb; i++) idle(1);
    check("mid_stb",  tx_stb,  1);
    check("mid_data", tx_data, 8'h55);
    rst_n = 1'b0;
    #1;
    check("async_stb",  tx_stb,  0);
    check("async_data", tx_data, 0);
    check("async_fill", fill,    0);
    check("async_ovf",  ovf,     0);
    check("async_err",  errc,    0);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
